led_chaser: RTL and testbench



---
 rtl/led_chaser.sv | 177 +++++++++++++++++
 tb/tb_led_chaser.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/led_chaser.sv
// led_chaser: parametrised running-light generator for the board LED bank.
// Modes: right (index up), left (index down), bounce, fill; selectable speed,
// run/freeze enable and a one-cycle step strobe. All outputs are registered.
// Optional build macro LED_CHASER_PWM_EN adds a 4-bit brightness input that
// gates lit LEDs with a free-running 16-step PWM.
module led_chaser #(
    parameter int unsigned N_LEDS      = 4,
    parameter int unsigned STEP_CYCLES = 50_000_000,
    parameter bit          ACTIVE_LOW  = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic [1:0]        speed,
`ifdef LED_CHASER_PWM_EN
    input  logic [3:0]        brightness,
`endif
    output logic [N_LEDS-1:0] led,
    output logic              step_pulse
);

    localparam int unsigned CW = $clog2(STEP_CYCLES + 1);
    localparam int unsigned PW = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;
    localparam logic [PW-1:0] POS_LAST = PW'(N_LEDS - 1);

    typedef enum logic [1:0] {
        MODE_RIGHT  = 2'b00,
        MODE_LEFT   = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_FILL   = 2'b11
    } mode_e;

    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CW-1:0]     period;
    logic [CW-1:0]     shifted;
    logic [PW-1:0]     pos_q, pos_d;
    logic              dir_up_q, dir_up_d;
    logic              bdir_up;
    mode_e             mode_q, mode_d;
    logic              started_q, started_d;
    logic [N_LEDS-1:0] lit_q, lit_d;
    logic              pulse_q, pulse_d;

    // Active-high lit mask for a given mode and position.
    function automatic logic [N_LEDS-1:0] pattern(input mode_e m, input logic [PW-1:0] p);
        logic [N_LEDS-1:0] pat;
        pat = '0;
        for (int unsigned i = 0; i < N_LEDS; i++) begin
            if (m == MODE_FILL) pat[i] = (i <= 32'(p));
            else                pat[i] = (i == 32'(p));
        end
        return pat;
    endfunction

    function automatic logic [N_LEDS-1:0] drive(input logic [N_LEDS-1:0] lit);
        return ACTIVE_LOW ? ~lit : lit;
    endfunction

    // Step period = max(1, STEP_CYCLES >> speed), re-evaluated every cycle.
    always_comb begin
        shifted = CW'(STEP_CYCLES) >> speed;
        period  = (shifted == '0) ? CW'(1) : shifted;
    end

    // State register: counter, position, direction, sampled mode, pattern.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            pos_q     <= '0;
            dir_up_q  <= 1'b1;
            mode_q    <= mode_e'(mode);
            started_q <= 1'b0;
            lit_q     <= '0;
            pulse_q   <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            pos_q     <= pos_d;
            dir_up_q  <= dir_up_d;
            mode_q    <= mode_d;
            started_q <= started_d;
            lit_q     <= lit_d;
            pulse_q   <= pulse_d;
        end
    end

    // Next-state: first enabled edge after reset only loads pattern(pos=0)
    // and leaves the counter at 0; later edges count or take a step.
    always_comb begin
        cnt_d     = cnt_q;
        pos_d     = pos_q;
        dir_up_d  = dir_up_q;
        mode_d    = mode_q;
        started_d = started_q;
        lit_d     = lit_q;
        pulse_d   = 1'b0;
        bdir_up   = dir_up_q;
        if (enable) begin
            if (!started_q) begin
                started_d = 1'b1;
                lit_d     = pattern(mode_q, pos_q);
            end else if (cnt_q >= period - CW'(1)) begin
                cnt_d   = '0;
                pulse_d = 1'b1;
                mode_d  = mode_e'(mode);
                // Entering bounce: head up unless already at the top end.
                if (mode_d == MODE_BOUNCE && mode_q != MODE_BOUNCE)
                    bdir_up = (pos_q != POS_LAST);
                case (mode_d)
                    MODE_RIGHT, MODE_FILL: begin
                        pos_d = (pos_q == POS_LAST) ? '0 : pos_q + PW'(1);
                    end
                    MODE_LEFT: begin
                        pos_d = (pos_q == '0) ? POS_LAST : pos_q - PW'(1);
                    end
                    MODE_BOUNCE: begin
                        if (N_LEDS == 1) begin
                            pos_d = '0;
                        end else if (bdir_up) begin
                            if (pos_q == POS_LAST) begin
                                dir_up_d = 1'b0;
                                pos_d    = pos_q - PW'(1);
                            end else begin
                                dir_up_d = 1'b1;
                                pos_d    = pos_q + PW'(1);
                            end
                        end else begin
                            if (pos_q == '0) begin
                                dir_up_d = 1'b1;
                                pos_d    = pos_q + PW'(1);
                            end else begin
                                dir_up_d = 1'b0;
                                pos_d    = pos_q - PW'(1);
                            end
                        end
                    end
                    default: pos_d = pos_q;
                endcase
                lit_d = pattern(mode_d, pos_d);
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

`ifdef LED_CHASER_PWM_EN
    logic [3:0]        pwm_cnt_q;
    logic [3:0]        pwm_cnt_d;
    logic [N_LEDS-1:0] led_q;

    assign pwm_cnt_d = pwm_cnt_q + 4'd1;

    // Free-running PWM; output register gates next lit mask by next PWM phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_cnt_q <= '0;
            led_q     <= drive('0);
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
            led_q     <= drive(lit_d & {N_LEDS{pwm_cnt_d <= brightness}});
        end
    end

    // Outputs straight from registers.
    always_comb begin
        led        = led_q;
        step_pulse = pulse_q;
    end
`else
    // Outputs straight from registers (polarity applied to the lit mask).
    always_comb begin
        led        = drive(lit_q);
        step_pulse = pulse_q;
    end
`endif

endmodule

// File: tb/tb_led_chaser.sv
// Self-checking bench for led_chaser (N_LEDS=4, STEP_CYCLES=10, ACTIVE_LOW=1).
module tb_led_chaser;

    localparam int N = 4;
    localparam int SC = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [1:0] speed = 2'b00;
    logic [3:0] led;
    logic       step_pulse;
`ifdef LED_CHASER_PWM_EN
    logic [3:0] brightness = 4'hF;
`endif

    led_chaser #(.N_LEDS(4), .STEP_CYCLES(10), .ACTIVE_LOW(1'b1)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .mode       (mode),
        .speed      (speed),
`ifdef LED_CHASER_PWM_EN
        .brightness (brightness),
`endif
        .led        (led),
        .step_pulse (step_pulse)
    );

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Reference model: position on a ring, bounce as a phase around 2N-2 slots.
    int m_pos, m_phase, m_mode, m_cnt, m_started, m_lit, m_pulse;

    function automatic int pat(input int md, input int p);
        if (md == 3) return (1 << (p + 1)) - 1;
        return 1 << p;
    endfunction

    task automatic model_edge(input logic r, input logic e, input logic [1:0] md, input logic [1:0] sp);
        int per;
        if (r) begin
            m_pos = 0; m_phase = 0; m_mode = int'(md); m_cnt = 0;
            m_started = 0; m_lit = 0; m_pulse = 0;
        end else if (!e) begin
            m_pulse = 0;
        end else if (m_started == 0) begin
            m_started = 1; m_lit = pat(m_mode, m_pos); m_pulse = 0;
        end else begin
            per = SC >> sp;
            if (per < 1) per = 1;
            if (m_cnt + 1 >= per) begin
                if (md == 2'd2) begin
                    if (m_mode != 2) m_phase = m_pos;
                    m_phase = (m_phase + 1) % (2 * N - 2);
                    m_pos = (m_phase < N) ? m_phase : (2 * N - 2 - m_phase);
                end else if (md == 2'd1) begin
                    m_pos = (m_pos + N - 1) % N;
                end else begin
                    m_pos = (m_pos + 1) % N;
                end
                m_mode = int'(md); m_cnt = 0; m_pulse = 1;
                m_lit = pat(m_mode, m_pos);
            end else begin
                m_cnt++; m_pulse = 0;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: model follows the same sampled inputs, outputs checked #1 later.
    task automatic tick();
        @(posedge clk);
        model_edge(reset, enable, mode, speed);
        #1;
        chk("model_led", 32'(led), 32'((~m_lit) & 4'hF));
        chk("model_pulse", 32'(step_pulse), 32'(m_pulse));
    endtask

    task automatic drive(input logic r, input logic e, input logic [1:0] md, input logic [1:0] sp);
        reset = r; enable = e; mode = md; speed = sp;
    endtask

    typedef struct {
        logic       rst;
        logic       en;
        logic [1:0] md;
        logic [1:0] sp;
        int         n;
        logic [3:0] exp_led;
        logic       exp_pulse;
    } vec_t;

    vec_t vecs[$];

    task automatic addv(input logic r, input logic e, input logic [1:0] md, input logic [1:0] sp,
                        input int n, input logic [3:0] l, input logic p);
        vec_t v;
        v.rst = r; v.en = e; v.md = md; v.sp = sp; v.n = n; v.exp_led = l; v.exp_pulse = p;
        vecs.push_back(v);
    endtask

    initial begin
        int n;
        // Right chaser from reset.
        addv(1, 0, 2'd0, 2'd0, 3,  4'b1111, 0);
        addv(0, 1, 2'd0, 2'd0, 1,  4'b1110, 0);
        addv(0, 1, 2'd0, 2'd0, 9,  4'b1110, 0);
        addv(0, 1, 2'd0, 2'd0, 1,  4'b1101, 1);
        addv(0, 1, 2'd0, 2'd0, 10, 4'b1011, 1);
        addv(0, 1, 2'd0, 2'd0, 10, 4'b0111, 1);
        addv(0, 1, 2'd0, 2'd0, 10, 4'b1110, 1);
        // Bounce from reset, no repeated end values.
        addv(1, 0, 2'd2, 2'd0, 2,  4'b1111, 0);
        addv(0, 1, 2'd2, 2'd0, 1,  4'b1110, 0);
        addv(0, 1, 2'd2, 2'd0, 10, 4'b1101, 1);
        addv(0, 1, 2'd2, 2'd0, 10, 4'b1011, 1);
        addv(0, 1, 2'd2, 2'd0, 10, 4'b0111, 1);
        addv(0, 1, 2'd2, 2'd0, 10, 4'b1011, 1);
        addv(0, 1, 2'd2, 2'd0, 10, 4'b1101, 1);
        addv(0, 1, 2'd2, 2'd0, 10, 4'b1110, 1);
        addv(0, 1, 2'd2, 2'd0, 10, 4'b1101, 1);
        addv(0, 1, 2'd2, 2'd0, 10, 4'b1011, 1);
        // Reset mid-run overrides enable, then restart at pos 0.
        addv(1, 1, 2'd2, 2'd0, 1,  4'b1111, 0);
        addv(0, 1, 2'd2, 2'd0, 1,  4'b1110, 0);
        // Fill.
        addv(1, 0, 2'd3, 2'd0, 1,  4'b1111, 0);
        addv(0, 1, 2'd3, 2'd0, 1,  4'b1110, 0);
        addv(0, 1, 2'd3, 2'd0, 10, 4'b1100, 1);
        addv(0, 1, 2'd3, 2'd0, 10, 4'b1000, 1);
        addv(0, 1, 2'd3, 2'd0, 10, 4'b0000, 1);
        addv(0, 1, 2'd3, 2'd0, 10, 4'b1110, 1);
        // Mode change mid-step waits for the next step edge.
        addv(0, 1, 2'd3, 2'd0, 5,  4'b1110, 0);
        addv(0, 1, 2'd1, 2'd0, 4,  4'b1110, 0);
        addv(0, 1, 2'd1, 2'd0, 1,  4'b0111, 1);
        // speed=3: period 1, a step every cycle.
        addv(0, 1, 2'd1, 2'd3, 1,  4'b1011, 1);
        addv(0, 1, 2'd1, 2'd3, 1,  4'b1101, 1);
        addv(0, 1, 2'd1, 2'd3, 1,  4'b1110, 1);
        addv(0, 1, 2'd1, 2'd3, 1,  4'b0111, 1);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].md, vecs[i].sp);
            for (int k = 0; k < vecs[i].n; k++) tick();
            chk($sformatf("vec%0d_led", i), 32'(led), 32'(vecs[i].exp_led));
            chk($sformatf("vec%0d_pulse", i), 32'(step_pulse), 32'(vecs[i].exp_pulse));
        end

        // Freeze at counter=4 for 25 cycles, then the step lands 6 cycles later.
        drive(1, 0, 2'd0, 2'd0); tick();
        drive(0, 1, 2'd0, 2'd0); tick();
        for (int k = 0; k < 4; k++) tick();
        drive(0, 0, 2'd0, 2'd0);
        for (int k = 0; k < 25; k++) begin
            tick();
            chk("hold_led", 32'(led), 32'(4'b1110));
            chk("hold_pulse", 32'(step_pulse), 32'(0));
        end
        drive(0, 1, 2'd0, 2'd0);
        n = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (step_pulse) begin n = k; break; end
        end
        chk("resume_step_delay", 32'(n), 32'(6));
        chk("resume_led", 32'(led), 32'(4'b1101));

        // Speed 0 -> 2 at counter=7: immediate step, then period 2.
        drive(1, 0, 2'd0, 2'd0); tick();
        drive(0, 1, 2'd0, 2'd0); tick();
        for (int k = 0; k < 7; k++) tick();
        chk("pre_speed_pulse", 32'(step_pulse), 32'(0));
        drive(0, 1, 2'd0, 2'd2); tick();
        chk("spd_step_now", 32'(step_pulse), 32'(1));
        chk("spd_step_led", 32'(led), 32'(4'b1101));
        tick();
        chk("spd_cnt_restart", 32'(step_pulse), 32'(0));
        tick();
        chk("spd_period2", 32'(step_pulse), 32'(1));
        chk("spd_period2_led", 32'(led), 32'(4'b1011));

        // Randomised run against the model.
        drive(1, 0, 2'd0, 2'd0); tick();
        for (int k = 0; k < 3000; k++) begin
            reset  = ($urandom_range(0, 99) == 0);
            enable = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 29) == 0) speed = 2'($urandom_range(0, 3));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
